// File: rtl/brief_pkg.sv
// Shared types and constants for the steered-BRIEF pair sequencer.
package brief_pkg;

  localparam int unsigned NPAIRS = 256;  // test pairs per keypoint, power of 2, <= 256
  localparam int unsigned FRAC   = 10;   // fractional bits of sin/cos
  localparam int unsigned COOR_W = 10;
  localparam int unsigned TRIG_W = 12;
  localparam int unsigned OFF_W  = 5;
  localparam int unsigned IDX_W  = 8;
  localparam int unsigned PROD_W = 17;   // OFF_W x TRIG_W signed product
  localparam int unsigned SUM_W  = 18;   // sum of two products
  localparam int unsigned ABS_W  = 12;   // signed absolute coordinate before clamping

  typedef logic signed [OFF_W-1:0]  off_t;
  typedef logic signed [TRIG_W-1:0] trig_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

endpackage

// File: rtl/brief_steer_if.sv
// Pair stream from the steering pipeline to the descriptor comparator (ready/valid).
interface brief_steer_if;
  import brief_pkg::*;

  logic              valid;
  logic              ready;
  logic              last;
  logic [IDX_W-1:0]  pair_idx;
  logic [COOR_W-1:0] ax;
  logic [COOR_W-1:0] ay;
  logic [COOR_W-1:0] bx;
  logic [COOR_W-1:0] by;

  modport master (output valid, last, pair_idx, ax, ay, bx, by, input ready);
  modport slave  (input valid, last, pair_idx, ax, ay, bx, by, output ready);

endinterface

// File: rtl/brief_pattern_rom.sv
// Fixed BRIEF test-pair pattern, combinational lookup by pair index.
// Returns signed offsets {ax, ay, bx, by}, each in [-15, 15]. The first entries are
// hand-placed reference pairs; the rest come from a fixed modular spread.
module brief_pattern_rom import brief_pkg::*; (
  input  logic [IDX_W-1:0] idx,
  output off_t             ax,
  output off_t             ay,
  output off_t             bx,
  output off_t             by
);

  function automatic off_t spread(input logic [IDX_W-1:0] i, input int mul, input int add);
    int v;
    v = ((int'(i) * mul + add) % 31) - 15;
    return off_t'(v);
  endfunction

  // Pattern table lookup
  always_comb begin
    ax = spread(idx, 7, 3);
    ay = spread(idx, 13, 5);
    bx = spread(idx, 11, 9);
    by = spread(idx, 17, 1);
    case (idx)
      8'd0: begin ax = 5'sd8;  ay = -5'sd3; bx = -5'sd8;  by = -5'sd8; end
      8'd1: begin ax = 5'sd5;  ay = 5'sd5;  bx = -5'sd15; by = 5'sd15; end
      8'd2: begin ax = 5'sd1;  ay = 5'sd0;  bx = 5'sd0;   by = 5'sd1;  end
      default: ;
    endcase
  end

endmodule

// File: rtl/brief_steer.sv
// Steered-BRIEF pair sequencer: pops one keypoint, walks the pattern ROM, rotates each
// offset by the keypoint orientation and streams clamped absolute sample points.
// Build option: define BRIEF_STEER_ROUND_EN to round half up before the fixed-point shift;
// otherwise the shift truncates toward -inf. Latency is identical in both builds.
module brief_steer import brief_pkg::*; #(
  parameter int unsigned IMG_W = 640,
  parameter int unsigned IMG_H = 480
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_key_valid,
  input  trig_t             i_sin,
  input  trig_t             i_cos,
  input  logic [COOR_W-1:0] i_coor_x,
  input  logic [COOR_W-1:0] i_coor_y,
  output logic              o_key_pop,
  output logic              o_busy,
  brief_steer_if.master     pair_if
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NPAIRS - 1);
`ifdef BRIEF_STEER_ROUND_EN
  localparam logic signed [SUM_W-1:0] Rnd = SUM_W'(1 << (FRAC - 1));
`else
  localparam logic signed [SUM_W-1:0] Rnd = '0;
`endif

  state_e            state_q;
  logic [IDX_W-1:0]  cnt_q;
  logic              key_pop_q;
  trig_t             sin_q, cos_q;
  logic [COOR_W-1:0] x_q, y_q;

  logic              s1_valid_q, s1_last_q;
  logic [IDX_W-1:0]  s1_idx_q;
  prod_t             s1_axc_q, s1_ays_q, s1_axs_q, s1_ayc_q;
  prod_t             s1_bxc_q, s1_bys_q, s1_bxs_q, s1_byc_q;

  logic              valid_q, last_q;
  logic [IDX_W-1:0]  idx_q;
  logic [COOR_W-1:0] ax_q, ay_q, bx_q, by_q;

  off_t rom_ax, rom_ay, rom_bx, rom_by;
  logic advance, issue;

  // The whole pipeline moves together; a stalled output freezes everything upstream.
  assign advance = !valid_q || pair_if.ready;
  assign issue   = (state_q == StRun) && advance;

  brief_pattern_rom u_rom (
    .idx (cnt_q),
    .ax  (rom_ax),
    .ay  (rom_ay),
    .bx  (rom_bx),
    .by  (rom_by)
  );

  function automatic prod_t mul(input off_t o, input trig_t t);
    return PROD_W'(o) * PROD_W'(t);
  endfunction

  // Combine two products, shift out the fraction, offset from the key and clamp.
  function automatic logic [COOR_W-1:0] steer(input logic [COOR_W-1:0] coor, input prod_t p0,
                                              input prod_t p1, input logic sub,
                                              input int unsigned lim);
    logic signed [SUM_W-1:0] sum;
    logic signed [ABS_W-1:0] v;
    sum = sub ? SUM_W'(p0) - SUM_W'(p1) : SUM_W'(p0) + SUM_W'(p1);
    sum = sum + Rnd;
    v = $signed({{(ABS_W - COOR_W){1'b0}}, coor}) + ABS_W'(sum >>> FRAC);
    if (v < 0) return '0;
    if (v > $signed(ABS_W'(lim - 1))) return COOR_W'(lim - 1);
    return COOR_W'(v);
  endfunction

  // Control FSM: key capture, pair counter and pop pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      key_pop_q <= 1'b0;
      sin_q     <= '0;
      cos_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
    end else begin
      key_pop_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_key_valid) begin
            sin_q     <= i_sin;
            cos_q     <= i_cos;
            x_q       <= i_coor_x;
            y_q       <= i_coor_y;
            cnt_q     <= '0;
            key_pop_q <= 1'b1;
            state_q   <= StRun;
          end
        end
        StRun: begin
          if (advance) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LastIdx) state_q <= StDrain;
          end
        end
        StDrain: begin
          if (valid_q && pair_if.ready && last_q) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Stage 1: register all eight offset x trig products
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_idx_q   <= '0;
      s1_axc_q   <= '0;
      s1_ays_q   <= '0;
      s1_axs_q   <= '0;
      s1_ayc_q   <= '0;
      s1_bxc_q   <= '0;
      s1_bys_q   <= '0;
      s1_bxs_q   <= '0;
      s1_byc_q   <= '0;
    end else if (advance) begin
      s1_valid_q <= issue;
      if (issue) begin
        s1_idx_q <= cnt_q;
        s1_last_q <= (cnt_q == LastIdx);
        s1_axc_q <= mul(rom_ax, cos_q);
        s1_ays_q <= mul(rom_ay, sin_q);
        s1_axs_q <= mul(rom_ax, sin_q);
        s1_ayc_q <= mul(rom_ay, cos_q);
        s1_bxc_q <= mul(rom_bx, cos_q);
        s1_bys_q <= mul(rom_by, sin_q);
        s1_bxs_q <= mul(rom_bx, sin_q);
        s1_byc_q <= mul(rom_by, cos_q);
      end
    end
  end

  // Stage 2: rotate, translate and clamp into the output registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      ax_q    <= '0;
      ay_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
    end else if (advance) begin
      valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        idx_q  <= s1_idx_q;
        last_q <= s1_last_q;
        ax_q   <= steer(x_q, s1_axc_q, s1_ays_q, 1'b1, IMG_W);
        ay_q   <= steer(y_q, s1_axs_q, s1_ayc_q, 1'b0, IMG_H);
        bx_q   <= steer(x_q, s1_bxc_q, s1_bys_q, 1'b1, IMG_W);
        by_q   <= steer(y_q, s1_bxs_q, s1_byc_q, 1'b0, IMG_H);
      end
    end
  end

  assign o_key_pop        = key_pop_q;
  assign o_busy           = (state_q != StIdle);
  assign pair_if.valid    = valid_q;
  assign pair_if.last     = valid_q && last_q;
  assign pair_if.pair_idx = idx_q;
  assign pair_if.ax       = ax_q;
  assign pair_if.ay       = ay_q;
  assign pair_if.bx       = bx_q;
  assign pair_if.by       = by_q;

endmodule
